// File: rtl/hood_pkg.sv
// hood_pkg: shared state enum, fan-level constants and seconds type for the range-hood controller
package hood_pkg;
   typedef enum logic [2:0] {
      ST_OFF, ST_STANDBY, ST_L1, ST_L2, ST_HUR, ST_COOLDOWN, ST_CLEAN, ST_DONE
   } state_t;
   localparam logic [1:0] FAN_OFF = 2'd0;
   localparam logic [1:0] FAN_L1  = 2'd1;
   localparam logic [1:0] FAN_L2  = 2'd2;
   localparam logic [1:0] FAN_HUR = 2'd3;
   typedef logic [7:0] sec_t;
   function automatic logic [1:0] fan_of(state_t s);
      return s == ST_L1 ? FAN_L1 :
             (s == ST_L2 || s == ST_COOLDOWN) ? FAN_L2 :
             s == ST_HUR ? FAN_HUR : FAN_OFF;
   endfunction
endpackage

// File: rtl/hood_sec_timer.sv
// hood_sec_timer: shared seconds countdown.
//   clk, rst      clock, sync active-high reset
//   tick          one-second pulse; decrements a non-zero count
//   load/load_val load strobe and value (load beats tick)
//   count         current remaining seconds
//   expire        tick arriving while count is 1 (count reaches 0 on this edge)
module hood_sec_timer
   import hood_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic load,
   input  sec_t load_val,
   output sec_t count,
   output logic expire
);
   sec_t count_d, count_q;
   always_comb count_d = load ? load_val : (tick && count_q != '0) ? count_q - 8'd1 : count_q;
   always_ff @(posedge clk) count_q <= rst ? '0 : count_d;
   assign count  = count_q;
   assign expire = tick && count_q == 8'd1;
endmodule

// File: rtl/hood_mode_ctrl.sv
// hood_mode_ctrl: range-hood mode arbiter/sequencer with shared seconds timer.
//   clk, rst                 clock, sync active-high reset
//   tick_1s                  one-second pulse
//   power_on                 power switch level (low forces OFF)
//   req_l1/req_l2/req_hur/req_clean/cancel  request pulses, priority cancel > clean > hur > l2 > l1
//   fan_level                0 off, 1 L1, 2 L2, 3 hurricane
//   cleaning, done           self-clean active / one-clk completion pulse
//   countdown                remaining seconds of the timed mode, else 0
//   hur_used                 hurricane consumed this power cycle
//   clean_reminder           fan-run reminder; only built with HOOD_CLEAN_REMINDER_EN, else 0
module hood_mode_ctrl
   import hood_pkg::*;
#(
   parameter int CLEAN_SEC     = 180,
   parameter int HURRICANE_SEC = 60,
   parameter int COOLDOWN_SEC  = 60,
   parameter int REMIND_SEC    = 36000
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1s,
   input  logic       power_on,
   input  logic       req_l1,
   input  logic       req_l2,
   input  logic       req_hur,
   input  logic       req_clean,
   input  logic       cancel,
   output logic [1:0] fan_level,
   output logic       cleaning,
   output logic [7:0] countdown,
   output logic       done,
   output logic       hur_used,
   output logic       clean_reminder
);
   state_t state_d, state_q;
   logic hur_used_d, hur_used_q;
   logic [1:0] fan_level_d, fan_level_q;
   logic cleaning_d, cleaning_q, done_d, done_q;
   logic w_clean, w_hur, w_l2, w_l1, hur_ok;
   logic tmr_load, tmr_expire;
   sec_t tmr_val, tmr_count;
   // only the single highest-priority request is ever visible to the FSM
   assign w_clean = req_clean & ~cancel;
   assign w_hur   = req_hur & ~(cancel | req_clean);
   assign w_l2    = req_l2 & ~(cancel | req_clean | req_hur);
   assign w_l1    = req_l1 & ~(cancel | req_clean | req_hur | req_l2);
   assign hur_ok  = w_hur & ~hur_used_q;
   hood_sec_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick_1s),
      .load     (tmr_load),
      .load_val (tmr_val),
      .count    (tmr_count),
      .expire   (tmr_expire)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_OFF;
         hur_used_q  <= 1'b0;
         fan_level_q <= FAN_OFF;
         cleaning_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hur_used_q  <= hur_used_d;
         fan_level_q <= fan_level_d;
         cleaning_q  <= cleaning_d;
         done_q      <= done_d;
      end
   end
   // requests are evaluated before expiry so a coinciding request wins over the tick
   always_comb begin
      state_d = state_q;
      if (!power_on) state_d = ST_OFF;
      else case (state_q)
         ST_OFF:       state_d = ST_STANDBY;
         ST_STANDBY:   state_d = w_clean ? ST_CLEAN : hur_ok ? ST_HUR : w_l2 ? ST_L2 : w_l1 ? ST_L1 : ST_STANDBY;
         ST_L1, ST_L2: state_d = cancel ? ST_STANDBY : hur_ok ? ST_HUR : w_l2 ? ST_L2 : w_l1 ? ST_L1 : state_q;
         ST_HUR:       state_d = cancel ? ST_COOLDOWN : w_l2 ? ST_L2 : w_l1 ? ST_L1 : tmr_expire ? ST_L2 : ST_HUR;
         ST_COOLDOWN:  state_d = w_l2 ? ST_L2 : w_l1 ? ST_L1 : tmr_expire ? ST_STANDBY : ST_COOLDOWN;
         ST_CLEAN:     state_d = cancel ? ST_STANDBY : tmr_expire ? ST_DONE : ST_CLEAN;
         default:      state_d = ST_STANDBY;
      endcase
      // any state change reloads the timer: duration for timed states, zero otherwise
      tmr_load   = state_d != state_q;
      tmr_val    = state_d == ST_HUR ? sec_t'(HURRICANE_SEC) :
                   state_d == ST_COOLDOWN ? sec_t'(COOLDOWN_SEC) :
                   state_d == ST_CLEAN ? sec_t'(CLEAN_SEC) : '0;
      hur_used_d = power_on && (hur_used_q || (tmr_load && state_d == ST_HUR));
   end
   always_comb begin
      fan_level_d = fan_of(state_d);
      cleaning_d  = state_d == ST_CLEAN;
      done_d      = state_d == ST_DONE;
   end
   assign fan_level = fan_level_q;
   assign cleaning  = cleaning_q;
   assign done      = done_q;
   assign hur_used  = hur_used_q;
   assign countdown = tmr_count;
`ifdef HOOD_CLEAN_REMINDER_EN
   logic [15:0] acc_d, acc_q;
   always_comb acc_d = (state_d == ST_DONE && state_q != ST_DONE) ? '0 :
                       (tick_1s && fan_level_q != FAN_OFF && acc_q != 16'(REMIND_SEC)) ? acc_q + 16'd1 : acc_q;
   always_ff @(posedge clk) acc_q <= rst ? '0 : acc_d;
   assign clean_reminder = acc_q == 16'(REMIND_SEC);
`else
   assign clean_reminder = 1'b0 && REMIND_SEC != 0;
`endif
endmodule

// File: doc/hood_mode_ctrl.md
# hood_mode_ctrl

Range-hood mode controller. It arbitrates the user requests (fan level 1, level 2, hurricane, self-clean, cancel) and sequences the hood through its operating modes. It owns the single shared seconds countdown used by self-clean, the time-limited hurricane mode and the post-hurricane cooldown. It sits between the debounced button/switch front-end and the fan driver / 7-segment display logic, and is driven by the one-second tick from the clock divider.

## Interface
- CLEAN_SEC, 180: self-clean duration in seconds (1..255)
- HURRICANE_SEC, 60: maximum hurricane run time in seconds (1..255)
- COOLDOWN_SEC, 60: delay before the fan stops after leaving hurricane for standby (1..255)
- REMIND_SEC, 36000: accumulated fan-run seconds before the clean reminder fires (1..65535)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick_1s  in  1  one-clk pulse per second
- power_on  in  1  hood power switch level, 1 = on
- req_l1 / req_l2 / req_hur / req_clean / cancel  in  1 each  single-cycle request pulses
- fan_level  out  2  0 off, 1 level 1, 2 level 2, 3 hurricane
- cleaning  out  1  high while self-clean runs
- countdown  out  8  remaining seconds of the active timed mode, 0 otherwise
- done  out  1  one-clk pulse when self-clean completes
- hur_used  out  1  hurricane already consumed this power cycle
- clean_reminder  out  1  clean-due indicator (see Configuration)

## Operation
- States: OFF, STANDBY, L1, L2, HUR, COOLDOWN, CLEAN, DONE.
- power_on low in any state:
  - next state OFF; hur_used cleared; any timed mode aborted.
  - done is not pulsed.
  - This takes priority over all requests.
- OFF -> STANDBY when power_on is high.
- Request priority within one cycle: cancel > req_clean > req_hur > req_l2 > req_l1. Only the winning request is acted on; the others are dropped.
- STANDBY:
  - req_l1 -> L1; req_l2 -> L2.
  - req_hur -> HUR, only if hur_used = 0.
  - req_clean -> CLEAN.
- L1 / L2:
  - req_l1 / req_l2 switch level.
  - req_hur -> HUR if hur_used = 0.
  - cancel -> STANDBY.
  - req_clean is ignored.
- HUR:
  - On entry, set hur_used and load HURRICANE_SEC.
  - At expiry -> L2.
  - req_l1 / req_l2 -> that level immediately.
  - cancel -> COOLDOWN, loading COOLDOWN_SEC, with fan_level held at 2.
- COOLDOWN:
  - At expiry -> STANDBY.
  - req_l1 / req_l2 -> that level.
  - Further cancel is ignored.
- CLEAN:
  - On entry, load CLEAN_SEC; cleaning = 1; fan_level = 0.
  - At expiry -> DONE.
  - cancel -> STANDBY with no done pulse.
  - All other requests are ignored.
- DONE: done = 1 for one clk, then STANDBY.
- Timer rules:
  - countdown is loaded on the entry clk edge.
  - On each tick_1s with countdown > 1: decrement.
  - On a tick_1s with countdown = 1: countdown becomes 0 and the state transitions on that same edge, so exactly N ticks elapse.
  - countdown is 0 in untimed states.
- Output decode by state:
  - fan_level: OFF/STANDBY/CLEAN/DONE = 0, L1 = 1, L2/COOLDOWN = 2, HUR = 3.
  - cleaning: CLEAN only.

## Timing
- All outputs are registered; state and outputs update on the same clk edge as the request.
- Request-to-output latency is 1 clk.
- A request coinciding with tick_1s: the request wins; the tick is consumed by the newly loaded timer only from the next tick onward.
- rst forces all of the following, regardless of power_on:
  - state OFF
  - countdown 0, fan_level 0
  - cleaning 0, done 0
  - hur_used 0, clean_reminder 0
  - reminder accumulator 0
- rst mid-CLEAN: no done pulse.

## Configuration
- HOOD_CLEAN_REMINDER_EN defined:
  - A 16-bit accumulator counts tick_1s while fan_level != 0, saturating at REMIND_SEC.
  - clean_reminder = 1 once the accumulator reaches REMIND_SEC.
  - Both are cleared when DONE is entered.
  - The accumulator is not cleared by power_on low.
- HOOD_CLEAN_REMINDER_EN undefined: accumulator omitted; clean_reminder tied to 0.

## Structure
- Shared package hood_pkg holds:
  - the state enum
  - fan-level constants (FAN_OFF, FAN_L1, FAN_L2, FAN_HUR)
  - the 8-bit seconds type
- One sub-module, hood_sec_timer: load value / load strobe / tick in, countdown and single-cycle expire out. It is instantiated once and shared by all timed states.

## Test plan
- Power on, req_clean, 180 ticks → cleaning high for exactly 180 ticks, countdown 180→1→0, done single pulse, STANDBY.
- req_hur from L1 → fan_level 3, hur_used 1, countdown 60; after 60 ticks → fan_level 2; second req_hur → ignored.
- HUR, cancel at countdown 40 → COOLDOWN, fan_level 2, countdown 60; after 60 ticks → fan_level 0.
- Same-cycle req_clean + req_hur in STANDBY → CLEAN entered; cancel at countdown 100 → STANDBY, done stays 0.
- power_on low at countdown 50 in CLEAN → OFF next clk, cleaning 0, no done; rst mid-HUR → all outputs reset values, hur_used 0.
- With HOOD_CLEAN_REMINDER_EN and REMIND_SEC=5: 5 ticks at L1 → clean_reminder 1; complete a clean → cleared.
